// File: rtl/fpga_msg_tx_pkg.sv
// Shared definitions for the FPGA<->PC message stream: word tags, status-word
// field positions and a constant log2 helper. The PC-side demux imports this too.
package fpga_msg_tx_pkg;

    localparam logic [1:0] TAG_CONT = 2'b00;
    localparam logic [1:0] TAG_EOF  = 2'b01;
    localparam logic [1:0] TAG_REC  = 2'b10;
    localparam logic [1:0] TAG_STAT = 2'b11;

    localparam int STAT_ERR_BIT  = 2;
    localparam int STAT_OVR_BIT  = 3;
    localparam int STAT_SEEN_BIT = 4;
    localparam int SEQ_W         = 20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REC,
        ST_EOF,
        ST_STAT
    } tx_state_e;

    // Smallest r with 2**r >= v.
    function automatic int log2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/fpga_msg_status_timer.sv
// Periodic status timer plus error edge detection; owns the status-pending,
// error-trigger and sticky error-seen flags.
module fpga_msg_status_timer
    import fpga_msg_tx_pkg::*;
#(
    parameter int STATUS_PERIOD = 65536
) (
    input  logic bus_clk,
    input  logic reset,
    input  logic error,
    input  logic stat_sent,
    output logic status_pending,
    output logic err_trig,
    output logic err_seen
);

    localparam int CNT_W = (log2(STATUS_PERIOD) < 1) ? 1 : log2(STATUS_PERIOD);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic pend_q, pend_d;
    logic trig_q, trig_d;
    logic seen_q, seen_d;
    logic err_prev_q, err_prev_d;
    logic wrap, err_rise;

    // A new request on the same cycle as an emission wins over the clear.
    always_comb begin
        wrap       = &cnt_q;
        err_rise   = error & ~err_prev_q;
        cnt_d      = cnt_q + 1'b1;
        err_prev_d = error;
        pend_d     = (pend_q & ~stat_sent) | wrap | err_rise;
        trig_d     = (trig_q & ~stat_sent) | err_rise;
        seen_d     = seen_q | err_rise;
    end

    always_ff @(posedge bus_clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            trig_q     <= 1'b0;
            seen_q     <= 1'b0;
            err_prev_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            trig_q     <= trig_d;
            seen_q     <= seen_d;
            err_prev_q <= err_prev_d;
        end
    end

    assign status_pending = pend_q;
    assign err_trig       = trig_q;
    assign err_seen       = seen_q;

endmodule

// File: rtl/fpga_msg_tx.sv
// FPGA-to-PC message transmitter: serialises FWFT result records into tagged
// words and interleaves EOF and status words, under host almost-full control.
module fpga_msg_tx
    import fpga_msg_tx_pkg::*;
#(
    parameter int XB_SIZE       = 32,
    parameter int REC_SIZE      = 90,
    parameter int N_FRAME_SIZE  = 20,
    parameter int STATUS_PERIOD = 65536
) (
    input  logic                    bus_clk,
    input  logic                    reset,
    input  logic                    rec_empty,
    input  logic [REC_SIZE-1:0]     rec,
    output logic                    rec_ack,
    input  logic                    eof,
    input  logic [N_FRAME_SIZE-1:0] n_frame,
    input  logic                    error,
    input  logic                    fpga_msg_full,
    output logic                    fpga_msg_valid,
    output logic [XB_SIZE-1:0]      fpga_msg
);

    localparam int P      = XB_SIZE - 2;
    localparam int N_WORD = REC_SIZE / P;
    localparam int IDX_W  = (N_WORD > 1) ? log2(N_WORD) : 1;

    tx_state_e              state_q, state_d;
    logic [REC_SIZE-1:0]    sr_q, sr_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [SEQ_W-1:0]       seq_q, seq_d;
    logic                   eof_pend_q, eof_pend_d;
    logic                   ovr_q, ovr_d;
    logic [N_FRAME_SIZE-1:0] nframe_q, nframe_d;
    logic                   valid_q, valid_d;
    logic [XB_SIZE-1:0]     msg_q, msg_d;

    logic status_pending, err_trig, err_seen;
    logic stat_sent, eof_sent;

    fpga_msg_status_timer #(
        .STATUS_PERIOD (STATUS_PERIOD)
    ) u_timer (
        .bus_clk        (bus_clk),
        .reset          (reset),
        .error          (error),
        .stat_sent      (stat_sent),
        .status_pending (status_pending),
        .err_trig       (err_trig),
        .err_seen       (err_seen)
    );

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        idx_d     = idx_q;
        seq_d     = seq_q;
        valid_d   = 1'b0;
        msg_d     = msg_q;
        rec_ack   = 1'b0;
        stat_sent = 1'b0;
        eof_sent  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fpga_msg_full) begin
                    if (status_pending && err_trig) begin
                        state_d = ST_STAT;
                    end else if (eof_pend_q) begin
                        state_d = ST_EOF;
                    end else if (!rec_empty) begin
                        // Word 0 leaves on the ack edge; the rest come from the shifter.
                        rec_ack = 1'b1;
                        sr_d    = rec >> P;
                        valid_d = 1'b1;
                        msg_d   = {rec[P-1:0], TAG_REC};
                        if (N_WORD == 1) begin
                            seq_d = seq_q + 1'b1;
                        end else begin
                            idx_d   = IDX_W'(1);
                            state_d = ST_REC;
                        end
                    end else if (status_pending) begin
                        state_d = ST_STAT;
                    end
                end
            end
            ST_REC: begin
                if (!fpga_msg_full) begin
                    valid_d = 1'b1;
                    msg_d   = {sr_q[P-1:0], TAG_CONT};
                    sr_d    = sr_q >> P;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_W'(N_WORD - 1)) begin
                        seq_d   = seq_q + 1'b1;
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_EOF: begin
                if (!fpga_msg_full) begin
                    valid_d  = 1'b1;
                    msg_d    = '0;
                    msg_d[XB_SIZE-1 -: N_FRAME_SIZE] = nframe_q;
                    msg_d[1:0] = TAG_EOF;
                    eof_sent = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_STAT: begin
                if (!fpga_msg_full) begin
                    valid_d   = 1'b1;
                    msg_d     = '0;
                    msg_d[1:0]           = TAG_STAT;
                    msg_d[STAT_ERR_BIT]  = error;
                    msg_d[STAT_OVR_BIT]  = ovr_q;
                    msg_d[STAT_SEEN_BIT] = err_seen;
                    msg_d[XB_SIZE-1 -: SEQ_W] = seq_q;
                    stat_sent = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (reset) rec_ack = 1'b0;

        // A fresh eof on the emission cycle re-arms the flag without counting as overrun.
        eof_pend_d = eof | (eof_pend_q & ~eof_sent);
        ovr_d      = ovr_q | (eof & eof_pend_q & ~eof_sent);
        nframe_d   = eof ? n_frame : nframe_q;
    end

    always_ff @(posedge bus_clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sr_q       <= '0;
            idx_q      <= '0;
            seq_q      <= '0;
            eof_pend_q <= 1'b0;
            ovr_q      <= 1'b0;
            nframe_q   <= '0;
            valid_q    <= 1'b0;
            msg_q      <= '0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            idx_q      <= idx_d;
            seq_q      <= seq_d;
            eof_pend_q <= eof_pend_d;
            ovr_q      <= ovr_d;
            nframe_q   <= nframe_d;
            valid_q    <= valid_d;
            msg_q      <= msg_d;
        end
    end

    assign fpga_msg_valid = valid_q;
    assign fpga_msg       = msg_q;

endmodule

// File: tb/tb_fpga_msg_tx.sv
// Bench for fpga_msg_tx: message-level reference model checked every cycle,
// plus directed scenarios with hand-computed word values.
module tb_fpga_msg_tx;

    localparam int XB = 32;
    localparam int RS = 90;
    localparam int NF = 20;
    localparam int SP = 64;
    localparam int P  = XB - 2;
    localparam int NW = RS / P;

    logic          bus_clk = 1'b0;
    logic          reset = 1'b1;
    logic          rec_empty = 1'b1;
    logic [RS-1:0] rec = '0;
    logic          rec_ack;
    logic          eof = 1'b0;
    logic [NF-1:0] n_frame = '0;
    logic          error = 1'b0;
    logic          fpga_msg_full = 1'b0;
    logic          fpga_msg_valid;
    logic [XB-1:0] fpga_msg;

    fpga_msg_tx #(
        .XB_SIZE(XB), .REC_SIZE(RS), .N_FRAME_SIZE(NF), .STATUS_PERIOD(SP)
    ) dut (
        .bus_clk        (bus_clk),
        .reset          (reset),
        .rec_empty      (rec_empty),
        .rec            (rec),
        .rec_ack        (rec_ack),
        .eof            (eof),
        .n_frame        (n_frame),
        .error          (error),
        .fpga_msg_full  (fpga_msg_full),
        .fpga_msg_valid (fpga_msg_valid),
        .fpga_msg       (fpga_msg)
    );

    always #5 bus_clk = ~bus_clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [XB-1:0] got, input logic [XB-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 40) $display("FAIL %s got=%h expected=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out t=%0t", name, $time);
    endtask

    // Record FIFO (FWFT): head shown on rec, popped the cycle after an ack.
    logic [RS-1:0] fifo[$];
    logic          ack_n = 1'b0;
    always @(negedge bus_clk) ack_n = rec_ack;
    always @(posedge bus_clk) begin
        #1;
        if (ack_n && fifo.size() > 0) fifo.delete(0);
        rec_empty = (fifo.size() == 0);
        rec       = (fifo.size() > 0) ? fifo[0] : '0;
    end

    // Reference model: one message at a time, chosen by priority when idle.
    logic          m_valid, m_eof, m_ovr, m_stat, m_trig, m_seen, m_eprev;
    logic          m_eemit, m_semit;
    logic [XB-1:0] m_msg;
    logic [XB-1:0] m_q[$];
    logic [NF-1:0] m_nf;
    logic [P-1:0]  m_pl;
    int            m_kind, m_timer, m_seq;

    always @(posedge bus_clk or posedge reset) begin
        if (reset) begin
            m_valid = 0; m_msg = '0; m_kind = 0; m_q.delete();
            m_eof = 0; m_ovr = 0; m_stat = 0; m_trig = 0; m_seen = 0; m_eprev = 0;
            m_nf = '0; m_timer = 0; m_seq = 0;
        end else begin
            m_valid = 0; m_eemit = 0; m_semit = 0;
            if (m_kind == 1) begin
                if (!fpga_msg_full) begin
                    m_valid = 1;
                    m_msg = m_q.pop_front();
                    if (m_q.size() == 0) begin m_seq++; m_kind = 0; end
                end
            end else if (m_kind == 2) begin
                if (!fpga_msg_full) begin
                    m_valid = 1; m_msg = {m_nf, 10'd0, 2'b01}; m_eemit = 1; m_kind = 0;
                end
            end else if (m_kind == 3) begin
                if (!fpga_msg_full) begin
                    m_valid = 1; m_msg = {m_seq[19:0], 7'd0, m_seen, m_ovr, error, 2'b11};
                    m_semit = 1; m_kind = 0;
                end
            end else if (!fpga_msg_full) begin
                if (m_stat && m_trig) m_kind = 3;
                else if (m_eof) m_kind = 2;
                else if (!rec_empty) begin
                    for (int k = 0; k < NW; k++) begin
                        m_pl = rec[k*P +: P];
                        m_q.push_back({m_pl, (k == 0) ? 2'b10 : 2'b00});
                    end
                    m_valid = 1; m_msg = m_q.pop_front(); m_kind = 1;
                end else if (m_stat) m_kind = 3;
            end
            if (eof) begin
                if (m_eof && !m_eemit) m_ovr = 1;
                m_eof = 1; m_nf = n_frame;
            end else if (m_eemit) m_eof = 0;
            if (m_semit) begin m_stat = 0; m_trig = 0; end
            if (error && !m_eprev) begin m_stat = 1; m_trig = 1; m_seen = 1; end
            m_eprev = error;
            m_timer++;
            if (m_timer == SP) begin m_timer = 0; m_stat = 1; end
        end
    end

    typedef struct {
        int          cyc;
        logic [31:0] w;
    } ent_t;
    ent_t wlog[$];
    int   cyc = 0;
    logic exp_ack;

    // Single compare process: every cycle, outputs against the model.
    always @(negedge bus_clk) begin
        cyc++;
        if (fpga_msg_valid) wlog.push_back('{cyc, fpga_msg});
        exp_ack = !reset && m_kind == 0 && !fpga_msg_full && !(m_stat && m_trig)
                  && !m_eof && !rec_empty;
        check("cyc_valid", fpga_msg_valid, m_valid);
        check("cyc_msg", fpga_msg, m_msg);
        check("cyc_rec_ack", rec_ack, exp_ack);
    end

    task automatic tick_n();
        @(negedge bus_clk);
        #1;
    endtask

    task automatic tick_p();
        @(posedge bus_clk);
        #1;
    endtask

    function automatic int find_val(input int start, input logic [31:0] val);
        for (int i = start; i < wlog.size(); i++) if (wlog[i].w == val) return i;
        return -1;
    endfunction

    function automatic int find_tag(input int start, input logic [1:0] tag);
        for (int i = start; i < wlog.size(); i++) if (wlog[i].w[1:0] == tag) return i;
        return -1;
    endfunction

    task automatic wait_word(input string name, input int start, input logic [31:0] val,
                             input bit by_tag, output int idx);
        idx = -1;
        for (int t = 0; t < 300 && idx < 0; t++) begin
            tick_n();
            idx = by_tag ? find_tag(start, val[1:0]) : find_val(start, val);
        end
        if (idx < 0) timeout_fail(name);
    endtask

    task automatic wait_size(input string name, input int n, output bit ok);
        for (int t = 0; t < 300 && wlog.size() < n; t++) tick_n();
        ok = (wlog.size() >= n);
        if (!ok) timeout_fail(name);
    endtask

    task automatic wait_ack(input string name);
        int t;
        t = 0;
        while (rec_ack !== 1'b1 && t < 200) begin tick_n(); t++; end
        if (rec_ack !== 1'b1) timeout_fail(name);
    endtask

    logic [RS-1:0] r1, r2, r3, r4, r5;
    int   i0, s0, e0, base, n, first_s, second_s;
    bit   ok;
    logic [31:0] wv;

    initial begin
        r1 = 90'h2_AAAA_AAAB_5555_5555_0123;
        r2 = {30'd1, 30'd2, 30'd3};
        r3 = {30'd11, 30'd12, 30'd13};
        r4 = {30'h3FFF_FFFF, 30'd0, 30'h3FFF_FFFF};
        r5 = {30'd21, 30'd22, 30'd23};

        // Reset: a record waiting in the FIFO must not be acked.
        fifo.push_back(r1);
        repeat (3) tick_n();
        check("reset_valid", fpga_msg_valid, 0);
        check("reset_msg", fpga_msg, 0);
        check("reset_ack", rec_ack, 0);
        tick_p();
        reset = 1'b0;

        // Record serialisation.
        wait_word("r1_w0", 0, 32'h5554_048E, 0, i0);
        if (i0 >= 0) begin
            wait_size("r1_words", i0 + 3, ok);
            if (ok) begin
                check("r1_w1", wlog[i0+1].w, 32'hAAB5_5554);
                check("r1_w2", wlog[i0+2].w, 32'h00AA_AAA8);
                check("r1_back_to_back", wlog[i0+2].cyc - wlog[i0].cyc, 2);
                wait_word("r1_status", i0 + 3, 32'h3, 1, s0);
                if (s0 >= 0) begin
                    wv = wlog[s0].w;
                    check("r1_status_seq", wv[31:12], 1);
                end
            end
        end

        // Backpressure for 5 cycles after word 0.
        base = wlog.size();
        fifo.push_back(r2);
        wait_ack("r2_ack");
        tick_p();
        fpga_msg_full = 1'b1;
        repeat (5) @(posedge bus_clk);
        #1 fpga_msg_full = 1'b0;
        wait_word("r2_w0", base, 32'hE, 0, i0);
        if (i0 >= 0) begin
            wait_size("r2_words", i0 + 3, ok);
            if (ok) begin
                check("r2_w1", wlog[i0+1].w, 32'h8);
                check("r2_w2", wlog[i0+2].w, 32'h4);
                check("r2_stall_gap", wlog[i0+1].cyc - wlog[i0].cyc, 6);
                check("r2_resume_gap", wlog[i0+2].cyc - wlog[i0+1].cyc, 1);
            end
        end

        // Priority: eof and error rise while a record is in flight.
        base = wlog.size();
        fifo.push_back(r3);
        fifo.push_back(r4);
        wait_ack("r3_ack");
        tick_p();
        eof = 1'b1; n_frame = 20'd7; error = 1'b1;
        tick_p();
        eof = 1'b0;
        wait_word("r3_w0", base, 32'h36, 0, i0);
        if (i0 >= 0) begin
            wait_size("prio_words", i0 + 8, ok);
            if (ok) begin
                check("prio_r3_w1", wlog[i0+1].w, 32'h30);
                check("prio_r3_w2", wlog[i0+2].w, 32'h2C);
                check("prio_status", wlog[i0+3].w, 32'h0000_3017);
                check("prio_eof", wlog[i0+4].w, 32'h0000_7001);
                check("prio_r4_w0", wlog[i0+5].w, 32'hFFFF_FFFE);
                check("prio_r4_w1", wlog[i0+6].w, 32'h0);
                check("prio_r4_w2", wlog[i0+7].w, 32'hFFFF_FFFC);
            end
        end
        error = 1'b0;

        // EOF overrun while the host FIFO is full.
        tick_p();
        base = wlog.size();
        fpga_msg_full = 1'b1;
        repeat (2) tick_p();
        eof = 1'b1; n_frame = 20'd3;
        tick_p();
        eof = 1'b0;
        tick_p();
        eof = 1'b1; n_frame = 20'd4;
        tick_p();
        eof = 1'b0;
        repeat (3) tick_p();
        fpga_msg_full = 1'b0;
        wait_word("ovr_eof", base, 32'h1, 1, e0);
        if (e0 >= 0) begin
            check("ovr_eof_word", wlog[e0].w, 32'h0000_4001);
            wait_word("ovr_status", e0 + 1, 32'h3, 1, s0);
            if (s0 >= 0) begin
                wv = wlog[s0].w;
                check("ovr_status_bit3", wv[3], 1);
                n = 0;
                for (int i = base; i < wlog.size(); i++) if (wlog[i].w[1:0] == 2'b01) n++;
                check("ovr_single_eof", n, 1);
            end
        end

        // Periodic status over 2*STATUS_PERIOD idle cycles.
        tick_n();
        base = wlog.size();
        repeat (2 * SP) tick_n();
        n = wlog.size() - base;
        check("period_count", n, 2);
        if (n == 2) begin
            first_s = base; second_s = base + 1;
            check("period_spacing", wlog[second_s].cyc - wlog[first_s].cyc, SP);
            wv = wlog[first_s].w;
            check("period_tag0", wv[1:0], 2'b11);
            check("period_seq0", wv[31:12], 4);
            wv = wlog[second_s].w;
            check("period_seq1", wv[31:12], 4);
        end

        // Reset mid-record, after word 1.
        base = wlog.size();
        fifo.push_back(r5);
        wait_word("r5_w1", base, 32'h58, 0, i0);
        #2 reset = 1'b1;
        #1;
        check("async_reset_valid", fpga_msg_valid, 0);
        check("async_reset_msg", fpga_msg, 0);
        repeat (2) tick_p();
        reset = 1'b0;
        base = wlog.size();
        wait_word("post_reset_status", base, 32'h3, 1, s0);
        if (s0 >= 0) begin
            wv = wlog[s0].w;
            check("post_reset_seq", wv[31:12], 0);
            check("r5_abandoned", find_val(base, 32'h54) < 0, 1);
            fifo.push_back(r1);
            wait_word("post_reset_rec", s0 + 1, 32'h2, 1, i0);
            if (i0 >= 0) check("post_reset_w0", wlog[i0].w, 32'h5554_048E);
        end

        repeat (5) tick_n();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
